// File: rtl/dram_latency_array.sv
// Byte-addressable data memory with a valid/ready request channel, per-byte write
// enables and a fixed, programmable access latency (one outstanding access).
module dram_latency_array #(
  parameter int    ADDR_W     = 16,
  parameter int    WORD_BYTES = 4,
  parameter int    LATENCY    = 4,
  parameter string INIT_HEX   = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WORD_BYTES-1:0]   req_be,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*WORD_BYTES-1:0] resp_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dram_latency_array: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [7:0]              mem [DEPTH];
  logic [ADDR_W-1:0]       lane_addr [WORD_BYTES];
  logic [8*WORD_BYTES-1:0] rd_word;
  logic                    accept;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_ready && req_valid;

  // Lane addresses wrap naturally by truncation to ADDR_W bits.
  always_comb begin
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      lane_addr[k] = req_addr + ADDR_W'(k);
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      rd_word[8*k +: 8] = mem[lane_addr[k]];
    end
  end

  always_ff @(posedge clock) begin
    if (accept && req_we) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        if (req_be[k]) mem[lane_addr[k]] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rdata <= req_we ? '0 : rd_word;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= BUSY;
              count <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_latency_array.sv
// Directed, table-driven bench for dram_latency_array (LATENCY=4 main instance,
// LATENCY=1 instance for the throughput check).
module tb_dram_latency_array;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic        req_ready, resp_valid;
  logic [15:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, resp_rdata;

  logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready;
  logic [31:0] r1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dram_latency_array #(.ADDR_W(16), .WORD_BYTES(4), .LATENCY(4), .INIT_HEX("")) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
  );

  dram_latency_array #(.ADDR_W(16), .WORD_BYTES(4), .LATENCY(1), .INIT_HEX("")) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_we(1'b0),
    .req_addr(16'h0000), .req_be(4'h0), .req_wdata(32'h0),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready), .resp_rdata(r1_rdata)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge and checks latency, data and the return to IDLE.
  task automatic run_req(input string name, input logic we, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int cyc;
    @(negedge clock);
    check({name, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_wdata = 32'h0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd4);
    check({name, " rdata"}, resp_rdata, exp);
    @(posedge clock);
    #1;
    check({name, " ready after"}, {30'b0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int cyc;
    int accepts, resps;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; resp_ready = 1'b1; r1_valid = 1'b0; r1_resp_ready = 1'b1;

    vecs[0] = '{1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 16'h0010, 4'b0000, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 16'h0011, 4'b0101, 32'h11223344, 32'h00000000};
    vecs[3] = '{1'b0, 16'h0010, 4'b1111, 32'h00000000, 32'h22AD44EF};
    vecs[4] = '{1'b1, 16'hFFFE, 4'b1111, 32'hA1B2C3D4, 32'h00000000};
    vecs[5] = '{1'b0, 16'hFFFE, 4'b0000, 32'h00000000, 32'hA1B2C3D4};
    vecs[6] = '{1'b1, 16'h0002, 4'b0011, 32'h77885566, 32'h00000000};
    vecs[7] = '{1'b0, 16'hFFFF, 4'b0000, 32'h00000000, 32'h66A1B2C3};
    vecs[8] = '{1'b1, 16'h0010, 4'b0000, 32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{1'b0, 16'h0010, 4'b0000, 32'h00000000, 32'h22AD44EF};

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("reset outputs", {resp_valid, req_ready, 30'b0}, 32'h0);
      check("reset rdata", resp_rdata, 32'h0);
    end
    reset = 1'b0;
    #1;
    check("ready after reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be,
              vecs[i].wdata, vecs[i].exp);
    end
    check("mem 0x0010", {24'b0, dut.mem[16'h0010]}, 32'hEF);
    check("mem 0x0013", {24'b0, dut.mem[16'h0013]}, 32'h22);
    check("mem 0xFFFF", {24'b0, dut.mem[16'hFFFF]}, 32'hC3);
    check("mem 0x0000", {24'b0, dut.mem[16'h0000]}, 32'hB2);

    // Backpressure: read held in RESP for 5 cycles; a write offered meanwhile is ignored
    resp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    @(posedge clock);
    @(negedge clock);
    req_we = 1'b1; req_be = 4'b1111; req_wdata = 32'h0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("bp latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp hold", {30'b0, resp_valid, req_ready}, 32'b10);
      check("bp rdata", resp_rdata, 32'h22AD44EF);
      @(negedge clock);
    end
    req_valid = 1'b0; req_we = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp release", {30'b0, resp_valid, req_ready}, 32'b01);
    run_req("after bp", 1'b0, 16'h0010, 4'b0000, 32'h0, 32'h22AD44EF);

    // Reset two cycles into a read: response is dropped
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready in reset", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready after mid reset", {31'b0, req_ready}, 32'd1);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (resp_valid) cyc++;
    end
    check("no dropped response", 32'(cyc), 32'd0);

    // Reset and req_valid together: write must not land
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010;
    req_be = 4'b1111; req_wdata = 32'h0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    #1;
    check("no accept in reset", {31'b0, resp_valid}, 32'd0);
    run_req("after reset write", 1'b0, 16'h0010, 4'b0000, 32'h0, 32'h22AD44EF);

    // LATENCY=1 stream: one access every 2 cycles
    @(negedge clock);
    r1_valid = 1'b1;
    accepts = 0; resps = 0;
    for (int i = 0; i < 20; i++) begin
      if (r1_ready && r1_valid) accepts++;
      if (r1_resp_valid) resps++;
      if (i == 1) check("lat1 first resp", {31'b0, r1_resp_valid}, 32'd1);
      @(negedge clock);
    end
    r1_valid = 1'b0;
    check("lat1 accepts", 32'(accepts), 32'd10);
    check("lat1 resps", 32'(resps), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
